// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton conditioner: channel FSM encoding and
// the counter-width helper used to size the debounce and hold counters.
package key_pkg;

  // Debounce FSM states; encodings are fixed so they read the same in waves and docs.
  typedef enum logic [1:0] {
    UP       = 2'd0,
    UP_CHK   = 2'd1,
    DOWN     = 2'd2,
    DOWN_CHK = 2'd3
  } key_state_e;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One pushbutton channel: synchroniser, four-state debounce FSM, debounce
// counter, saturating hold counter and registered level/strobe/hold outputs.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = 500000,
  parameter int unsigned HoldCycles     = 50000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,    // raw button, active-low, asynchronous
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);

  localparam int unsigned DebW  = cnt_width(DebounceCycles);
  localparam int unsigned HoldW = cnt_width(HoldCycles);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  key_s;

  key_state_e            state_q, state_d;
  logic [DebW-1:0]       deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;

  logic                  level_q, level_d;
  logic                  press_q, press_d;
  logic                  release_q, release_d;
  logic                  hold_q, hold_d;
  logic                  in_down;

  // Synchroniser; resets to the released level so a held key after reset looks like a fresh press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], key_ni};
    end
  end

  assign key_s   = ~sync_q[SyncStages-1];
  assign in_down = (state_q == DOWN) || (state_q == DOWN_CHK);

  // FSM state and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UP;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_q == deb_cnt_d ? deb_cnt_q : deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state and counter update; the hold counter runs only while the key is down.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      UP: begin
        if (key_s) begin
          state_d   = UP_CHK;
          deb_cnt_d = '0;
        end
      end
      UP_CHK: begin
        if (!key_s) begin
          state_d = UP;
        end else if (deb_cnt_q == DebMax) begin
          state_d    = DOWN;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!key_s) begin
          state_d   = DOWN_CHK;
          deb_cnt_d = '0;
        end
        if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      DOWN_CHK: begin
        if (key_s) begin
          // Bounce back to pressed: keep the hold count running.
          state_d = DOWN;
        end else if (deb_cnt_q == DebMax) begin
          state_d = UP;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
        if (hold_cnt_q != HoldMax) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = UP;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the current FSM decision.
  always_comb begin
    press_d   = (state_q == UP_CHK) && key_s && (deb_cnt_q == DebMax);
    release_d = (state_q == DOWN_CHK) && !key_s && (deb_cnt_q == DebMax);
    level_d   = (state_d == DOWN) || (state_d == DOWN_CHK);
    hold_d    = in_down && (hold_cnt_q == HoldMax) && !release_d;
  end

  // Output registers so level, strobes and hold all change on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/key_conditioner.sv
// DE1-SoC pushbutton conditioner: one independent debounce channel per KEY,
// outputs concatenated bit-per-key with no cross-channel logic.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_channel #(
      .SyncStages    (SYNC_STAGES),
      .DebounceCycles(DEBOUNCE_CYCLES),
      .HoldCycles    (HOLD_CYCLES)
    ) u_chan (
      .clk_i    (CLOCK_50),
      .rst_ni   (reset_n),
      .key_ni   (KEY[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .hold_o   (key_hold[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a strobe scoreboard: every expected
// press/release strobe is queued with its due cycle when the key is driven.
module tb_key_conditioner;

  localparam int unsigned Lat = 2 + 8 + 1;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
  } ev_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] key;
  logic [3:0] key_level, key_press, key_release, key_hold;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  ev_t         exp_q[$];
  ev_t         mon_e;

  key_conditioner #(
    .NUM_KEYS       (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (32)
  ) dut (
    .CLOCK_50   (clk),
    .reset_n    (reset_n),
    .KEY        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic go_to(input int unsigned t);
    if (cyc > t) chk("schedule", cyc, t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int unsigned c, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endtask

  // Strobe monitor: any strobe must match the oldest expectation; an overdue one is a miss.
  always @(negedge clk) begin
    if ((key_press & key_release) !== 4'h0) chk("press_and_release", {key_press, key_release}, 0);
    if (key_press !== 4'h0 || key_release !== 4'h0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {key_press, key_release}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_cycle", cyc, mon_e.cyc);
        chk("strobe_press", {28'h0, key_press}, {28'h0, mon_e.press});
        chk("strobe_release", {28'h0, key_release}, {28'h0, mon_e.rel});
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      chk("missing_strobe", {24'h0, key_press, key_release}, {24'h0, mon_e.press, mon_e.rel});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    reset_n = 1'b0;
    key     = 4'hF;
    @(negedge clk);
    go_to(3);
    chk("reset_outputs", {key_level, key_press, key_release, key_hold}, 0);
    reset_n = 1'b1;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", {key_level, key_press, key_release, key_hold}, 0);
    end

    // Single press on KEY[0].
    t = cyc;
    key[0] = 1'b0;
    push(t + Lat, 4'h1, 4'h0);
    go_to(t + Lat - 1);
    chk("k0_level_before", {28'h0, key_level}, 4'h0);
    go_to(t + Lat);
    chk("k0_level_at_press", {28'h0, key_level}, 4'h1);
    go_to(t + Lat + 1);
    chk("k0_level_after", {28'h0, key_level}, 4'h1);
    go_to(t + 20);
    key[0] = 1'b1;
    push(t + 20 + Lat, 4'h0, 4'h1);
    go_to(t + 40);
    chk("k0_level_released", {28'h0, key_level}, 4'h0);

    // Glitch on KEY[1]: five cycles low is too short.
    t = cyc;
    key[1] = 1'b0;
    go_to(t + 5);
    key[1] = 1'b1;
    go_to(t + 30);
    chk("k1_glitch_level", {28'h0, key_level}, 4'h0);

    // Three bounces then hold: one press timed from the last falling edge.
    t = cyc;
    key[1] = 1'b0;
    go_to(t + 2); key[1] = 1'b1;
    go_to(t + 3); key[1] = 1'b0;
    go_to(t + 5); key[1] = 1'b1;
    go_to(t + 6); key[1] = 1'b0;
    push(t + 6 + Lat, 4'h2, 4'h0);
    go_to(t + 30);
    chk("k1_bounce_level", {28'h0, key_level}, 4'h2);
    key[1] = 1'b1;
    push(t + 30 + Lat, 4'h0, 4'h2);
    go_to(t + 50);

    // Long press on KEY[2]: hold 32 cycles after press, cleared with release.
    t = cyc;
    key[2] = 1'b0;
    push(t + Lat, 4'h4, 4'h0);
    go_to(t + Lat + 31);
    chk("k2_hold_early", {28'h0, key_hold}, 4'h0);
    go_to(t + Lat + 32);
    chk("k2_hold_rise", {28'h0, key_hold}, 4'h4);
    go_to(t + 60);
    key[2] = 1'b1;
    push(t + 60 + Lat, 4'h0, 4'h4);
    go_to(t + 60 + Lat - 1);
    chk("k2_hold_before_release", {28'h0, key_hold}, 4'h4);
    go_to(t + 60 + Lat);
    chk("k2_hold_at_release", {28'h0, key_hold}, 4'h0);
    chk("k2_level_at_release", {28'h0, key_level}, 4'h0);
    go_to(t + 80);

    // All keys together, then KEY[3] alone released.
    t = cyc;
    key = 4'h0;
    push(t + Lat, 4'hF, 4'h0);
    go_to(t + 20);
    key[3] = 1'b1;
    push(t + 20 + Lat, 4'h0, 4'h8);
    go_to(t + 40);
    chk("all_level_after_k3", {28'h0, key_level}, 4'h7);
    key = 4'hF;
    push(t + 40 + Lat, 4'h0, 4'h7);
    go_to(t + 60);

    // Reset mid-debounce of KEY[0] while KEY[3] is long-held.
    t = cyc;
    key[3] = 1'b0;
    push(t + Lat, 4'h8, 4'h0);
    go_to(t + 50);
    key[0] = 1'b0;
    go_to(t + 57);
    chk("pre_reset_level", {28'h0, key_level}, 4'h8);
    chk("pre_reset_hold", {28'h0, key_hold}, 4'h8);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    chk("reset_abort", {key_level, key_press, key_release, key_hold}, 0);
    go_to(t + 60);
    reset_n = 1'b1;
    push(t + 60 + Lat, 4'h9, 4'h0);
    go_to(t + 60 + Lat - 1);
    chk("post_reset_level_before", {28'h0, key_level}, 4'h0);
    go_to(t + 60 + Lat);
    chk("post_reset_level", {28'h0, key_level}, 4'h9);
    chk("post_reset_hold", {28'h0, key_hold}, 4'h0);
    go_to(t + 80);
    key = 4'hF;
    push(t + 80 + Lat, 4'h0, 4'h9);
    go_to(t + 100);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
